// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter for N requesters.
//
// Each requester keeps the grant for up to weight[i] consecutive cycles
// (a weight of 0 behaves as 1). Then priority rotates to the requester after
// the current owner. The grant is registered and one-hot, and there is no idle
// cycle between back-to-back owners.
//
// Optional feature (compile-time macro WRR_LOCK_EN): adds an N-bit lock input.
// While the owner keeps both req and lock asserted, quantum expiry is
// ignored and the grant is held.
module wrr_arbiter #(
  parameter int N   = 4,
  parameter int WW  = 3,
  parameter int IDW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
`ifdef WRR_LOCK_EN
  input  logic [N-1:0]    lock,
`endif
  output logic [N-1:0]    grant,
  output logic [IDW-1:0]  grant_id,
  output logic            busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [WW-1:0]  cnt_q, cnt_d;
  logic [WW-1:0]  wlat_q, wlat_d;
  logic [N-1:0]   grant_d;
  logic [IDW-1:0] gid_d;

  logic [IDW-1:0] base;
  logic [IDW-1:0] pick_idx;
  logic           pick_found;
  logic [WW-1:0]  pick_w;
  logic           owner_req;
  logic           owner_hold;

  // Index after idx, wrapping at N-1 (N need not be a power of two).
  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
    if (idx == IDW'(N - 1)) return '0;
    return idx + IDW'(1);
  endfunction

  // base + k modulo N, for 0 <= k < N.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] b, input int k);
    int j;
    j = int'(b) + k;
    if (j >= N) j = j - N;
    return IDW'(j);
  endfunction

  // A zero weight still grants one cycle.
  function automatic logic [WW-1:0] sat_weight(input logic [WW-1:0] w);
    if (w == '0) return WW'(1);
    return w;
  endfunction

  // Scan origin: the stored pointer when idle, or the slot after the owner
  // when a rotation is being evaluated. Using the owner directly means the
  // re-pick sees the new pointer at the same edge that stores it.
  always_comb begin
    if (state_q == S_GRANT) base = next_idx(grant_id);
    else                    base = ptr_q;
  end

  // First requester at or after base, in circular order.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap_add(base, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(base, k);
      end
    end
  end

  // Weight of the requester that would start a quantum this edge.
  always_comb begin
    pick_w = sat_weight(weight[int'(pick_idx)*WW +: WW]);
  end

  // Decide whether the current owner keeps the grant for another cycle.
  always_comb begin
    owner_req  = req[grant_id];
    owner_hold = owner_req && (cnt_q < wlat_q);
`ifdef WRR_LOCK_EN
    if (owner_req && lock[grant_id]) owner_hold = 1'b1;
`endif
  end

  // Next-state logic: start, hold, rotate or go idle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wlat_d  = wlat_q;
    grant_d = grant;
    gid_d   = grant_id;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d           = S_GRANT;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gid_d             = pick_idx;
          cnt_d             = WW'(1);
          wlat_d            = pick_w;
        end
      end
      default: begin
        if (owner_hold) begin
          // Saturate at the latched weight (only reachable while locked).
          if (cnt_q < wlat_q) cnt_d = cnt_q + WW'(1);
        end else begin
          ptr_d = base;
          if (pick_found) begin
            grant_d           = '0;
            grant_d[pick_idx] = 1'b1;
            gid_d             = pick_idx;
            cnt_d             = WW'(1);
            wlat_d            = pick_w;
          end else begin
            state_d = S_IDLE;
            grant_d = '0;
            gid_d   = '0;
            cnt_d   = '0;
          end
        end
      end
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      wlat_q   <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      wlat_q   <= wlat_d;
      grant    <= grant_d;
      grant_id <= gid_d;
      busy     <= |grant_d;
    end
  end

endmodule
